// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: datapath width,
// instruction size and the fetch FSM state encoding.
package instruction_fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_out_reg.sv
// Fetch-to-decode output register: holds one instruction and its address
// until decode accepts it; a redirect flushes it.
module fetch_out_reg
  import instruction_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            load,
  input  logic            ready,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  // Flush beats load, and load beats consume so a same-cycle refill keeps valid high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Single-outstanding-request instruction fetch stage with redirect/flush
// and response draining after a redirect.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instruction,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            req_valid;
  logic            rsp_load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    req_valid = 1'b0;
    rsp_load  = 1'b0;
    case (state_q)
      FETCH: begin
        // Only request when the output register will be free to take the response.
        req_valid = (!id_valid || id_ready) && !redirect_valid;
        if (req_valid && imem_req_ready) begin
          addr_d  = pc_q;
          pc_d    = pc_q + XLEN'(INSTR_BYTES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          state_d = imem_rsp_valid ? FETCH : DRAIN;
        end else if (imem_rsp_valid) begin
          rsp_load = 1'b1;
          state_d  = FETCH;
        end
      end
      DRAIN: begin
        if (imem_rsp_valid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (redirect_valid) pc_d = redirect_pc & ~XLEN'(INSTR_BYTES - 1);
  end

  assign imem_req_valid = req_valid && rst_n;
  assign imem_req_addr  = pc_q;

  fetch_out_reg u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .load       (rsp_load),
    .ready      (id_ready),
    .load_instr (imem_rsp_data),
    .load_pc    (addr_q),
    .valid      (id_valid),
    .instr      (id_instruction),
    .pc         (id_pc)
  );

  assign id_pc_plus4 = id_pc + XLEN'(INSTR_BYTES);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: default and top-of-memory RESET_PC instances.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;

  logic        req_valid,  id_valid;
  logic [31:0] req_addr,   id_instruction, id_pc, id_pc_plus4;
  logic        req_valid2, id_valid2;
  logic [31:0] req_addr2,  id_instruction2, id_pc2, id_pc_plus42;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instruction (id_instruction),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_top (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (req_valid2),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (req_addr2),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid2),
    .id_ready       (id_ready),
    .id_instruction (id_instruction2),
    .id_pc          (id_pc2),
    .id_pc_plus4    (id_pc_plus42)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge (input drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;

    tick(); tick(); #1;
    check_eq("rst_req_valid", {31'b0, req_valid}, 32'd0);
    check_eq("rst_id_valid",  {31'b0, id_valid},  32'd0);
    check_eq("rst_id_instr",  id_instruction,      32'h0);
    check_eq("rst_id_pc",     id_pc,               32'h0);

    // Basic fetch: request at RESET_PC, response one cycle later.
    rst_n = 1'b1; #1;
    check_eq("first_req_valid", {31'b0, req_valid}, 32'd1);
    check_eq("first_req_addr",  req_addr,           32'h0);
    check_eq("top_first_addr",  req_addr2,          32'hFFFF_FFFC);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h2002_0005; #1;
    check_eq("wait_req_valid", {31'b0, req_valid}, 32'd0);
    tick();
    imem_rsp_valid = 1'b0; id_ready = 1'b0; #1;
    check_eq("dlv_id_valid", {31'b0, id_valid}, 32'd1);
    check_eq("dlv_instr",    id_instruction,     32'h2002_0005);
    check_eq("dlv_pc",       id_pc,              32'h0);
    check_eq("dlv_pc4",      id_pc_plus4,        32'h4);
    check_eq("top_dlv_pc",   id_pc2,             32'hFFFF_FFFC);
    check_eq("top_dlv_pc4",  id_pc_plus42,       32'h0);
    check_eq("stall_req_valid", {31'b0, req_valid}, 32'd0);

    // Decode stall: outputs hold, no request.
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      check_eq("stall_valid", {31'b0, id_valid},  32'd1);
      check_eq("stall_instr", id_instruction,      32'h2002_0005);
      check_eq("stall_pc",    id_pc,               32'h0);
      check_eq("stall_req",   {31'b0, req_valid}, 32'd0);
    end
    id_ready = 1'b1; #1;
    check_eq("unstall_req_valid", {31'b0, req_valid}, 32'd1);
    check_eq("unstall_req_addr",  req_addr,           32'h4);
    check_eq("top_second_addr",   req_addr2,          32'h0);

    // Redirect in WAIT, stale response two cycles later is drained.
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; #1;
    check_eq("consumed_id_valid", {31'b0, id_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0; #1;
    check_eq("drain_req_valid", {31'b0, req_valid}, 32'd0);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0; #1;
    check_eq("stale_id_valid", {31'b0, id_valid}, 32'd0);
    check_eq("redir_req_valid", {31'b0, req_valid}, 32'd1);
    check_eq("redir_req_addr",  req_addr,           32'h100);

    // Redirect coincident with a response.
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0; #1;
    check_eq("coinc_id_valid", {31'b0, id_valid}, 32'd0);
    check_eq("coinc_req_addr", req_addr,           32'h200);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0040_0093;
    tick();
    imem_rsp_valid = 1'b0; #1;
    check_eq("dlv2_valid", {31'b0, id_valid}, 32'd1);
    check_eq("dlv2_instr", id_instruction,     32'h0040_0093);
    check_eq("dlv2_pc",    id_pc,              32'h200);
    check_eq("dlv2_pc4",   id_pc_plus4,        32'h204);
    check_eq("dlv2_req",   req_addr,           32'h204);

    // Misaligned redirect in FETCH: aligned target, flush, request blocked.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #1;
    check_eq("redir_blocks_req", {31'b0, req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0; #1;
    check_eq("align_flush_valid", {31'b0, id_valid}, 32'd0);
    check_eq("align_req_addr",    req_addr,           32'h100);

    // Redirect in WAIT then again in DRAIN with a coincident response.
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    redirect_pc = 32'h0000_0400; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
    tick();
    redirect_valid = 1'b0; imem_rsp_valid = 1'b0; #1;
    check_eq("drain_redir_valid", {31'b0, id_valid},  32'd0);
    check_eq("drain_redir_req",   {31'b0, req_valid}, 32'd1);
    check_eq("drain_redir_addr",  req_addr,           32'h400);

    // Reset while a request is outstanding.
    tick();
    rst_n = 1'b0; #1;
    check_eq("midrst_req_valid", {31'b0, req_valid}, 32'd0);
    tick();
    rst_n = 1'b1; #1;
    check_eq("postrst_req_valid", {31'b0, req_valid}, 32'd1);
    check_eq("postrst_req_addr",  req_addr,           32'h0);
    check_eq("postrst_id_valid",  {31'b0, id_valid},  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
